pw_verify: RTL and testbench
============================

Name: pw_verify

Overview:
- Reader side of the doorlock password store. Collects keypad digits into its own entry buffer, packed the same way as the stored-password register, then compares that buffer against the stored 128-bit password one nibble per cycle in constant time.
- Issues unlock/deny pulses and tracks consecutive failures.
- Enforces a timed lockout after too many consecutive failures.
- Sits between the keypad decoder and the lock actuator, and reads the stored-password register's 128-bit output.

Parameters:
- NIBBLES, 32, number of 4-bit digit slots in the password (stored width = 4*NIBBLES).
- MAX_FAIL, 3, consecutive denies that trigger lockout (1..15).
- LOCK_CYCLES, 1000, lockout duration in clk cycles (>=1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- stored_pw  in  4*NIBBLES  stored password: unused slots 4'hF at MSB end, newest digit at [3:0].
- key_valid  in  1  1-cycle strobe, key_data is a digit.
- key_data  in  4  digit 0x0..0xE; 0xF is reserved and ignored.
- key_enter  in  1  1-cycle strobe, submit the entry.
- key_clear  in  1  1-cycle strobe, discard the entry.
- unlock  out  1  1-cycle pulse on match.
- deny  out  1  1-cycle pulse on mismatch or empty store.
- locked  out  1  high during lockout.
- busy  out  1  high in CHECK or LOCKOUT.
- pw_empty  out  1  stored_pw is all 4'hF (combinational).
- entry_full  out  1  entry buffer holds NIBBLES digits.
- fail_cnt  out  4  consecutive failure count.

Behaviour:
- Reset values:
  - Entry buffer = all 4'hF; digit count = 0.
  - State IDLE.
  - unlock, deny, locked, busy, entry_full = 0; fail_cnt = 0.
  - Snapshot register = all 4'hF; compare index = 0; mismatch flag = 0.
- Entry buffer packing: a digit shifts in at [3:0] and existing contents shift left by 4, so the layout matches stored_pw.
- States:
  - IDLE: buffer empty. A valid digit → ENTRY. key_enter → CHECK.
  - ENTRY: accepts digits. key_clear → IDLE with buffer reset. key_enter → CHECK.
  - CHECK: serial compare, exactly NIBBLES cycles.
  - LOCKOUT: counts down LOCK_CYCLES.
- Input priority in IDLE/ENTRY, same cycle: key_clear > key_enter > key_valid. A lower-priority strobe in that cycle is dropped.
- Digit rules:
  - key_data = 4'hF is ignored.
  - When digit count = NIBBLES, further digits are ignored and entry_full stays 1 until clear or submit.
- On key_enter:
  - stored_pw is captured into the snapshot register.
  - Index is set to 0 and the mismatch flag cleared.
  - busy = 1 from the next cycle.
  - Changes to stored_pw during CHECK have no effect.
- CHECK:
  - Each cycle, compare snapshot nibble[idx] with buffer nibble[idx] and OR any difference into the mismatch flag.
  - No early exit.
  - After the idx = NIBBLES-1 compare, the result is registered.
- Result (pulse high the cycle after the last compare, i.e. NIBBLES+1 cycles after the key_enter cycle):
  - Snapshot all 4'hF: deny = 1; fail_cnt unchanged; → IDLE.
  - Otherwise, mismatch = 0: unlock = 1; fail_cnt ← 0; → IDLE.
  - Otherwise, mismatch = 1: deny = 1; fail_cnt ← fail_cnt+1. If the new count = MAX_FAIL → LOCKOUT, otherwise → IDLE.
- Entry buffer and digit count are cleared in the result cycle in all cases.
- An empty entry compared against a non-empty store is a normal mismatch.
- LOCKOUT:
  - locked = busy = 1.
  - All key strobes are ignored.
  - After LOCK_CYCLES cycles: fail_cnt ← 0, locked = 0, → IDLE.
- Strobes during CHECK are ignored; they are not queued.
- unlock and deny are never high together.
- fail_cnt saturates at MAX_FAIL.
- rstn low at any time, including mid-CHECK or mid-LOCKOUT, returns immediately to reset values. No pulse is emitted.

Test Plan:
- stored_pw = 112 bits of F followed by 16'h1234; keys 1,2,3,4 then enter → unlock = 1 exactly 33 cycles after the enter cycle (NIBBLES = 32); fail_cnt = 0; buffer cleared.
- Same store; keys 1,2,3,5, enter → deny pulse only; fail_cnt = 1. Then a correct entry → unlock; fail_cnt = 0.
- Three wrong entries (MAX_FAIL = 3, LOCK_CYCLES = 20) → third deny, locked = 1 for 20 cycles; a correct entry during lockout is ignored; afterwards locked = 0, fail_cnt = 0, and a correct entry unlocks.
- stored_pw all F; keys 7, enter → deny; pw_empty = 1; fail_cnt remains 0.
- 33 digits of 0x5 with stored = 32 digits of 0x5 → entry_full = 1 after the 32nd digit; the 33rd is ignored; enter → unlock. Separately: key 0xF ignored; clear + enter in the same cycle → buffer cleared, no CHECK.
- Entry 1234, enter, change stored_pw on cycle 5 of CHECK → still unlock. Assert rstn low on cycle 10 of CHECK → no pulse, all outputs at reset values.

Source files
------------

// File: rtl/pw_verify.sv
// Password verifier: collects keypad digits, compares them against the stored password
// one nibble per cycle in constant time, and enforces a timed lockout after repeated failures.
//  state     | meaning
//  S_IDLE    | entry buffer empty, waiting for a digit or submit
//  S_ENTRY   | collecting digits
//  S_CHECK   | serial nibble compare, exactly NIBBLES cycles
//  S_LOCKOUT | keypad ignored for LOCK_CYCLES cycles
module pw_verify #(
    parameter int NIBBLES     = 32,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [4*NIBBLES-1:0] stored_pw,
    input  logic                 key_valid,
    input  logic [3:0]           key_data,
    input  logic                 key_enter,
    input  logic                 key_clear,
    output logic                 unlock,
    output logic                 deny,
    output logic                 locked,
    output logic                 busy,
    output logic                 pw_empty,
    output logic                 entry_full,
    output logic [3:0]           fail_cnt
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CNT_W = $clog2(NIBBLES + 1);
    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [W-1:0]     ALL_F     = {NIBBLES{4'hF}};
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NIBBLES);
    localparam logic [LCK_W-1:0] LOCK_LOAD = LCK_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       FAIL_MAX  = 4'(MAX_FAIL);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOCKOUT} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     entry_buf;
    logic [W-1:0]     snap;
    logic [CNT_W-1:0] digit_cnt;
    logic [IDX_W-1:0] idx;
    logic             mismatch;
    logic [LCK_W-1:0] lock_cnt;

    logic       in_entry, do_clear, do_enter, do_digit;
    logic       last_cmp, nib_diff, mm_final, snap_empty, go_lock, lock_done;
    logic [3:0] fail_inc;

    assign pw_empty   = (stored_pw == ALL_F);
    assign entry_full = (digit_cnt == FULL_CNT);

    // clear beats enter beats digit; the losers in that cycle are dropped
    assign in_entry = (state == S_IDLE) || (state == S_ENTRY);
    assign do_clear = in_entry && key_clear;
    assign do_enter = in_entry && !key_clear && key_enter;
    assign do_digit = in_entry && !key_clear && !key_enter && key_valid
                      && (key_data != 4'hF) && !entry_full;

    assign last_cmp   = (state == S_CHECK) && (idx == LAST_IDX);
    assign nib_diff   = (snap[idx*4 +: 4] != entry_buf[idx*4 +: 4]);
    assign mm_final   = mismatch | nib_diff;
    assign snap_empty = (snap == ALL_F);
    assign fail_inc   = (fail_cnt < FAIL_MAX) ? fail_cnt + 4'd1 : fail_cnt;
    assign go_lock    = last_cmp && !snap_empty && mm_final && (fail_inc == FAIL_MAX);
    assign lock_done  = (state == S_LOCKOUT) && (lock_cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (do_enter)      state_nxt = S_CHECK;
                else if (do_digit) state_nxt = S_ENTRY;
            end
            S_ENTRY: begin
                if (do_clear)      state_nxt = S_IDLE;
                else if (do_enter) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (last_cmp) state_nxt = go_lock ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (lock_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        locked = (state == S_LOCKOUT);
        busy   = (state == S_CHECK) || (state == S_LOCKOUT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entry_buf <= ALL_F;
            digit_cnt <= '0;
            snap      <= ALL_F;
            idx       <= '0;
            mismatch  <= 1'b0;
            unlock    <= 1'b0;
            deny      <= 1'b0;
            fail_cnt  <= 4'd0;
            lock_cnt  <= '0;
        end else begin
            unlock <= 1'b0;
            deny   <= 1'b0;
            if (do_clear) begin
                entry_buf <= ALL_F;
                digit_cnt <= '0;
            end else if (do_enter) begin
                snap     <= stored_pw;
                idx      <= '0;
                mismatch <= 1'b0;
            end else if (do_digit) begin
                entry_buf <= (entry_buf << 4) | W'(key_data);
                digit_cnt <= digit_cnt + CNT_W'(1);
            end

            // every nibble is visited even after a difference is found
            if (state == S_CHECK) begin
                mismatch <= mm_final;
                if (!last_cmp) begin
                    idx <= idx + IDX_W'(1);
                end else begin
                    idx       <= '0;
                    entry_buf <= ALL_F;
                    digit_cnt <= '0;
                    if (snap_empty) begin
                        deny <= 1'b1;
                    end else if (!mm_final) begin
                        unlock   <= 1'b1;
                        fail_cnt <= 4'd0;
                    end else begin
                        deny     <= 1'b1;
                        fail_cnt <= fail_inc;
                        if (go_lock) lock_cnt <= LOCK_LOAD;
                    end
                end
            end

            if (state == S_LOCKOUT) begin
                if (lock_cnt != '0) lock_cnt <= lock_cnt - LCK_W'(1);
                else                fail_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_pw_verify.sv
// Bench for pw_verify: a transaction-level model predicts outputs every cycle,
// directed scenarios add hand-computed literal checks.
module tb_pw_verify;
    localparam int N    = 32;
    localparam int MAXF = 3;
    localparam int LCK  = 20;
    localparam logic [127:0] ALL_F  = {32{4'hF}};
    localparam logic [127:0] PW1234 = {{28{4'hF}}, 16'h1234};
    localparam logic [127:0] PW5S   = {32{4'h5}};

    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] stored_pw = ALL_F;
    logic         key_valid = 1'b0;
    logic [3:0]   key_data  = 4'h0;
    logic         key_enter = 1'b0;
    logic         key_clear = 1'b0;
    logic         unlock, deny, locked, busy, pw_empty, entry_full;
    logic [3:0]   fail_cnt;

    int total = 0;
    int bad   = 0;

    pw_verify #(.NIBBLES(N), .MAX_FAIL(MAXF), .LOCK_CYCLES(LCK)) dut (
        .clk(clk), .rstn(rstn), .stored_pw(stored_pw),
        .key_valid(key_valid), .key_data(key_data), .key_enter(key_enter), .key_clear(key_clear),
        .unlock(unlock), .deny(deny), .locked(locked), .busy(busy),
        .pw_empty(pw_empty), .entry_full(entry_full), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    // model: digit list, remaining check cycles, remaining lockout cycles
    int           m_digits[$];
    int           m_check_left;
    int           m_lock_left;
    int           m_fail;
    bit           m_unlock, m_deny, m_pass, m_snap_empty;

    function automatic logic [127:0] pack_digits(input int d[$]);
        logic [127:0] v = ALL_F;
        foreach (d[i]) v = {v[123:0], 4'(d[i])};
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_digits.delete();
            m_check_left = 0; m_lock_left = 0; m_fail = 0;
            m_unlock = 0; m_deny = 0; m_pass = 0; m_snap_empty = 0;
        end else begin
            m_unlock = 0;
            m_deny   = 0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fail = 0;
            end else if (m_check_left > 0) begin
                m_check_left--;
                if (m_check_left == 0) begin
                    m_digits.delete();
                    if (m_snap_empty) m_deny = 1;
                    else if (m_pass) begin
                        m_unlock = 1; m_fail = 0;
                    end else begin
                        m_deny = 1;
                        if (m_fail < MAXF) m_fail++;
                        if (m_fail == MAXF) m_lock_left = LCK;
                    end
                end
            end else if (key_clear) begin
                m_digits.delete();
            end else if (key_enter) begin
                m_snap_empty = (stored_pw == ALL_F);
                m_pass       = (pack_digits(m_digits) == stored_pw);
                m_check_left = N;
            end else if (key_valid && key_data != 4'hF && m_digits.size() < N) begin
                m_digits.push_back(int'(key_data));
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] act, expv;
        act  = {unlock, deny, locked, busy, pw_empty, entry_full, fail_cnt};
        expv = {m_unlock, m_deny, m_lock_left > 0, (m_check_left > 0) || (m_lock_left > 0),
                stored_pw == ALL_F, m_digits.size() == N, 4'(m_fail)};
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL cycle_model t=%0t got=%b want=%b (unlock,deny,locked,busy,empty,full,fail)",
                     $time, act, expv);
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp_v);
        end
    endtask

    task automatic strobe(input bit v, input logic [3:0] d, input bit e, input bit c);
        key_valid = v; key_data = d; key_enter = e; key_clear = c;
        @(posedge clk); #1;
        key_valid = 0; key_enter = 0; key_clear = 0;
    endtask

    task automatic key(input logic [3:0] d);
        strobe(1, d, 0, 0);
    endtask

    task automatic enter();
        strobe(0, 4'h0, 1, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic keys1234();
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    endtask

    // returns cycles from the enter cycle to the first pulse (bounded)
    task automatic wait_result(output int n);
        n = 1;
        while (!unlock && !deny && n < 60) begin
            @(posedge clk); #1; n++;
        end
    endtask

    int n;

    initial begin
        rstn = 1'b0;
        idle(3);
        chk("rst_unlock", unlock, 0); chk("rst_deny", deny, 0);
        chk("rst_busy", busy, 0); chk("rst_fail", fail_cnt, 0);
        rstn = 1'b1;
        idle(2);

        stored_pw = PW1234;
        keys1234(); enter();
        wait_result(n);
        chk("ok_latency", n, 33); chk("ok_unlock", unlock, 1); chk("ok_deny", deny, 0);
        chk("ok_fail", fail_cnt, 0);
        idle(1);
        chk("ok_pulse_width", unlock, 0);

        key(4'h1); key(4'h2); key(4'h3); key(4'h5); enter();
        wait_result(n);
        chk("bad_deny", deny, 1); chk("bad_unlock", unlock, 0); chk("bad_fail", fail_cnt, 1);
        idle(1);
        keys1234(); enter();
        wait_result(n);
        chk("retry_unlock", unlock, 1); chk("retry_fail", fail_cnt, 0);
        idle(1);

        for (int i = 0; i < 3; i++) begin
            key(4'h9); enter();
            wait_result(n);
            chk("lock_deny", deny, 1);
            if (i < 2) idle(1);
        end
        chk("lock_on", locked, 1); chk("lock_fail", fail_cnt, 3);
        keys1234(); enter();
        idle(13);
        chk("lock_cycle19", locked, 1);
        idle(1);
        chk("lock_cycle20", locked, 1);
        idle(1);
        chk("lock_released", locked, 0); chk("lock_fail_clr", fail_cnt, 0);
        chk("lock_no_unlock", unlock, 0);
        keys1234(); enter();
        wait_result(n);
        chk("post_lock_unlock", unlock, 1);
        idle(1);

        stored_pw = ALL_F;
        idle(1);
        chk("empty_flag", pw_empty, 1);
        key(4'h7); enter();
        wait_result(n);
        chk("empty_deny", deny, 1); chk("empty_fail", fail_cnt, 0);
        idle(1);

        stored_pw = PW5S;
        for (int i = 0; i < 32; i++) key(4'h5);
        chk("full_at_32", entry_full, 1);
        key(4'h5);
        chk("full_at_33", entry_full, 1);
        enter();
        wait_result(n);
        chk("full_unlock", unlock, 1); chk("full_cleared", entry_full, 0);
        idle(1);

        stored_pw = PW1234;
        key(4'h1); key(4'hF); key(4'h2); key(4'h3); key(4'h4); enter();
        wait_result(n);
        chk("f_ignored_unlock", unlock, 1);
        idle(1);
        key(4'h9);
        strobe(0, 4'h0, 1, 1);
        chk("clr_enter_busy", busy, 0);
        keys1234(); enter();
        wait_result(n);
        chk("clr_enter_unlock", unlock, 1);
        idle(1);

        keys1234(); enter();
        idle(4);
        stored_pw = {{28{4'hF}}, 16'h9999};
        wait_result(n);
        chk("snapshot_unlock", unlock, 1);
        idle(1);
        stored_pw = PW1234;
        key(4'h8); enter();
        wait_result(n);
        chk("pre_rst_fail", fail_cnt, 1);
        idle(1);
        keys1234(); enter();
        idle(9);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0); chk("midrst_fail", fail_cnt, 0);
        chk("midrst_unlock", unlock, 0); chk("midrst_full", entry_full, 0);
        idle(2);
        rstn = 1'b1;
        idle(40);
        chk("midrst_no_pulse", unlock | deny, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
